// File: rtl/dcache_dirty_wb_seq.sv
// dcache_dirty_wb_seq: dirty-line writeback sequencer for single evictions and full flush walks.
// Reads the dirty array, issues a valid/ready writeback for dirty lines, then clears them.
module dcache_dirty_wb_seq #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_req,
  output logic                  flush_done,
  input  logic                  evict_req,
  input  logic [ADDR_WIDTH-1:0] evict_addr,
  output logic                  evict_busy,
  output logic                  evict_ack,
  output logic                  evict_was_dirty,
  output logic [ADDR_WIDTH-1:0] dirty_rd_addr,
  output logic                  dirty_rd_en,
  input  logic                  read_dirty,
  output logic                  wb_valid,
  output logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic                  wb_ready,
  output logic                  dirty_clr_en,
  output logic [ADDR_WIDTH-1:0] dirty_clr_addr
);
  localparam logic [2:0] IDLE = 3'd0, RD = 3'd1, CHK = 3'd2, WB = 3'd3, CLR = 3'd4, NEXT = 3'd5, DONE = 3'd6;
  localparam logic MODE_EVICT = 1'b0, MODE_FLUSH = 1'b1;
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;
  logic [2:0] state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic mode_q, mode_d, ack_q, ack_d, was_q, was_d;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    mode_d = mode_q;
    ack_d = 1'b0;
    was_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (evict_req) begin
          idx_d = evict_addr;
          mode_d = MODE_EVICT;
          state_d = RD;
        end else if (flush_req) begin
          idx_d = '0;
          mode_d = MODE_FLUSH;
          state_d = RD;
        end
      end
      RD: state_d = CHK;
      CHK: begin
        ack_d = !read_dirty && mode_q == MODE_EVICT;
        state_d = read_dirty ? WB : mode_q == MODE_EVICT ? IDLE : NEXT;
      end
      WB: state_d = wb_ready ? CLR : WB;
      CLR: begin
        ack_d = mode_q == MODE_EVICT;
        was_d = mode_q == MODE_EVICT;
        state_d = mode_q == MODE_EVICT ? IDLE : NEXT;
      end
      NEXT: begin
        idx_d = idx_q == LAST ? idx_q : idx_q + ADDR_WIDTH'(1);
        state_d = idx_q == LAST ? DONE : RD;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      mode_q <= MODE_EVICT;
      ack_q <= 1'b0;
      was_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      mode_q <= mode_d;
      ack_q <= ack_d;
      was_q <= was_d;
    end
  end
  // rst gates wb_valid directly so a stalled handshake is withdrawn at once
  assign wb_valid        = (state_q == WB) & ~rst;
  assign wb_addr         = idx_q;
  assign evict_busy      = state_q != IDLE;
  assign dirty_rd_en     = state_q == RD;
  assign dirty_rd_addr   = idx_q;
  assign dirty_clr_en    = state_q == CLR;
  assign dirty_clr_addr  = idx_q;
  assign flush_done      = state_q == DONE;
  assign evict_ack       = ack_q;
  assign evict_was_dirty = was_q;
endmodule
